// File: rtl/ddi_signal_pkg.sv
// rtl/ddi_signal_pkg.sv - shared state codes, priority encodings and timing constants
package ddi_signal_pkg;

    typedef enum logic [3:0] {
        ST_ALL_RED   = 4'd0,
        ST_E_GREEN   = 4'd1,
        ST_E_YELLOW  = 4'd2,
        ST_E_CLEAR   = 4'd3,
        ST_W_GREEN   = 4'd4,
        ST_W_YELLOW  = 4'd5,
        ST_W_CLEAR   = 4'd6,
        ST_MAINT_ON  = 4'd7,
        ST_MAINT_OFF = 4'd8,
        ST_FAULT     = 4'd15
    } light_t;

    localparam logic [3:0] ILLEGAL_LO = 4'd9;
    localparam logic [3:0] ILLEGAL_HI = 4'd14;

    typedef enum logic [1:0] {
        PRI_NONE  = 2'b00,
        PRI_EAST  = 2'b01,
        PRI_WEST  = 2'b10,
        PRI_ALIAS = 2'b11
    } prio_t;

    localparam logic [5:0] DEF_GREEN_T     = 6'd20;
    localparam logic [5:0] DEF_GREEN_PRI_T = 6'd40;
    localparam logic [5:0] DEF_GREEN_MIN_T = 6'd10;
    localparam logic [5:0] DEF_YELLOW_T    = 6'd4;
    localparam logic [5:0] DEF_CLEAR_T     = 6'd2;
    localparam logic [5:0] DEF_STARTUP_T   = 6'd2;

    function automatic logic is_illegal(input logic [3:0] code);
        return (code >= ILLEGAL_LO) && (code <= ILLEGAL_HI);
    endfunction

endpackage

// File: rtl/ddi_signal_phase_timer.sv
// rtl/ddi_signal_phase_timer.sv - per-phase cycle counter, restarted on every state change
module ddi_signal_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       phase_start,
    input  logic [5:0] duration,
    output logic       timing_done
);

    logic [5:0] count;

    // Saturates so a long stay in FAULT or maintenance never wraps into a false done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 6'd0;
        end else if (phase_start) begin
            count <= 6'd0;
        end else if (count != 6'h3f) begin
            count <= count + 6'd1;
        end
    end

    assign timing_done = (count == (duration - 6'd1));

endmodule

// File: rtl/ddi_signal_top.sv
// rtl/ddi_signal_top.sv - diverging-diamond two-phase signal controller with maintenance flash and sticky fault
module ddi_signal_top
    import ddi_signal_pkg::*;
#(
    parameter logic [5:0] GREEN_T     = DEF_GREEN_T,
    parameter logic [5:0] GREEN_PRI_T = DEF_GREEN_PRI_T,
    parameter logic [5:0] GREEN_MIN_T = DEF_GREEN_MIN_T,
    parameter logic [5:0] YELLOW_T    = DEF_YELLOW_T,
    parameter logic [5:0] CLEAR_T     = DEF_CLEAR_T,
    parameter logic [5:0] STARTUP_T   = DEF_STARTUP_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] prio,
    input  logic       maintenance,
    output logic [3:0] light_state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] prio_q;
    logic [5:0] duration;
    logic       phase_start;
    logic       timing_done;

    // Green length comes from the priority latched at green entry, not the live input.
    always_comb begin
        duration = 6'd1;
        case (state_q)
            ST_ALL_RED:  duration = STARTUP_T;
            ST_E_GREEN: begin
                case (prio_q)
                    PRI_EAST: duration = GREEN_PRI_T;
                    PRI_WEST: duration = GREEN_MIN_T;
                    default:  duration = GREEN_T;
                endcase
            end
            ST_W_GREEN: begin
                case (prio_q)
                    PRI_WEST: duration = GREEN_PRI_T;
                    PRI_EAST: duration = GREEN_MIN_T;
                    default:  duration = GREEN_T;
                endcase
            end
            ST_E_YELLOW, ST_W_YELLOW: duration = YELLOW_T;
            ST_E_CLEAR,  ST_W_CLEAR:  duration = CLEAR_T;
            default:     duration = 6'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (is_illegal(state_q) || (state_q == ST_FAULT)) begin
            state_d = ST_FAULT;
        end else if (maintenance) begin
            state_d = (state_q == ST_MAINT_ON) ? ST_MAINT_OFF : ST_MAINT_ON;
        end else if ((state_q == ST_MAINT_ON) || (state_q == ST_MAINT_OFF)) begin
            state_d = ST_ALL_RED;
        end else if (timing_done) begin
            case (state_q)
                ST_ALL_RED:  state_d = ST_E_GREEN;
                ST_E_GREEN:  state_d = ST_E_YELLOW;
                ST_E_YELLOW: state_d = ST_E_CLEAR;
                ST_E_CLEAR:  state_d = ST_W_GREEN;
                ST_W_GREEN:  state_d = ST_W_YELLOW;
                ST_W_YELLOW: state_d = ST_W_CLEAR;
                ST_W_CLEAR:  state_d = ST_E_GREEN;
                default:     state_d = ST_FAULT;
            endcase
        end
    end

    assign phase_start = (state_d != state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ALL_RED;
            prio_q  <= PRI_NONE;
        end else begin
            state_q <= state_d;
            if (phase_start && ((state_d == ST_E_GREEN) || (state_d == ST_W_GREEN))) begin
                prio_q <= prio;
            end
        end
    end

    ddi_signal_phase_timer u_phase_timer (
        .clk         (clk),
        .rst         (rst),
        .phase_start (phase_start),
        .duration    (duration),
        .timing_done (timing_done)
    );

    assign light_state = state_q;

endmodule

// File: tb/tb_ddi_signal_top.sv
// tb/tb_ddi_signal_top.sv - directed self-checking bench for ddi_signal_top
module tb_ddi_signal_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] prio;
    logic       maintenance;
    logic [3:0] light_state;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int t_eg;

    ddi_signal_top dut (
        .clk         (clk),
        .rst         (rst),
        .prio        (prio),
        .maintenance (maintenance),
        .light_state (light_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge in the first cycle of a phase; returns at the first cycle of the next one.
    task automatic expect_phase(input string tag, input logic [3:0] code, input int len);
        int n;
        n = 0;
        check({tag, " state"}, 8'(light_state), 8'(code));
        while ((light_state == code) && (n < 200)) begin
            n++;
            @(negedge clk);
        end
        check({tag, " len"}, 8'(n), 8'(len));
    endtask

    task automatic do_reset(input logic [1:0] p);
        @(negedge clk);
        rst = 1'b0;
        prio = p;
        maintenance = 1'b0;
        #1;
        check("reset async", 8'(light_state), 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        prio = 2'b00;
        maintenance = 1'b0;
        #22;
        check("reset state", 8'(light_state), 8'd0);

        // no-priority ring and 52-cycle recurrence
        do_reset(2'b00);
        expect_phase("r0 all_red", 4'd0, 2);
        t_eg = cyc;
        expect_phase("r0 e_green", 4'd1, 20);
        expect_phase("r0 e_yellow", 4'd2, 4);
        expect_phase("r0 e_clear", 4'd3, 2);
        expect_phase("r0 w_green", 4'd4, 20);
        expect_phase("r0 w_yellow", 4'd5, 4);
        expect_phase("r0 w_clear", 4'd6, 2);
        check("r0 period", 8'(cyc - t_eg), 8'd52);
        check("r0 e_green again", 8'(light_state), 8'd1);

        // east priority
        do_reset(2'b01);
        expect_phase("p1 all_red", 4'd0, 2);
        expect_phase("p1 e_green", 4'd1, 40);
        expect_phase("p1 e_yellow", 4'd2, 4);
        expect_phase("p1 e_clear", 4'd3, 2);
        expect_phase("p1 w_green", 4'd4, 10);

        // west priority
        do_reset(2'b10);
        expect_phase("p2 all_red", 4'd0, 2);
        expect_phase("p2 e_green", 4'd1, 10);
        expect_phase("p2 e_yellow", 4'd2, 4);
        expect_phase("p2 e_clear", 4'd3, 2);
        expect_phase("p2 w_green", 4'd4, 40);

        // priority change mid-green takes effect at the next green entry
        do_reset(2'b00);
        expect_phase("pc all_red", 4'd0, 2);
        expect_phase("pc e_green", 4'd1, 20);
        expect_phase("pc e_yellow", 4'd2, 4);
        expect_phase("pc e_clear", 4'd3, 2);
        prio = 2'b01;
        expect_phase("pc w_green held", 4'd4, 20);
        expect_phase("pc w_yellow", 4'd5, 4);
        expect_phase("pc w_clear", 4'd6, 2);
        expect_phase("pc e_green pri", 4'd1, 40);
        prio = 2'b11;
        expect_phase("p3 e_yellow", 4'd2, 4);
        expect_phase("p3 e_clear", 4'd3, 2);
        expect_phase("p3 w_green", 4'd4, 20);
        expect_phase("p3 w_yellow", 4'd5, 4);
        expect_phase("p3 w_clear", 4'd6, 2);
        expect_phase("p3 e_green", 4'd1, 20);

        // maintenance flash entered from E_GREEN
        do_reset(2'b00);
        expect_phase("m all_red", 4'd0, 2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        maintenance = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check("maint alt", 8'(light_state), (i % 2 == 1) ? 8'd7 : 8'd8);
        end
        maintenance = 1'b0;
        @(negedge clk);
        expect_phase("m exit all_red", 4'd0, 2);
        expect_phase("m exit e_green", 4'd1, 20);

        // corrupted state encoding goes to sticky FAULT
        @(negedge clk);
        force dut.state_q = 4'd12;
        @(posedge clk);
        #1 release dut.state_q;
        @(negedge clk);
        @(negedge clk);
        check("fault entry", 8'(light_state), 8'd15);
        for (int i = 0; i < 50; i++) begin
            maintenance = i[0];
            prio = 2'(i);
            @(negedge clk);
            check("fault sticky", 8'(light_state), 8'd15);
        end
        maintenance = 1'b0;
        do_reset(2'b00);
        expect_phase("f rec all_red", 4'd0, 2);
        expect_phase("f rec e_green", 4'd1, 20);
        expect_phase("f rec e_yellow", 4'd2, 4);
        expect_phase("f rec e_clear", 4'd3, 2);
        expect_phase("f rec w_green", 4'd4, 20);

        // async reset in the middle of W_YELLOW
        check("pre-reset w_yellow", 8'(light_state), 8'd5);
        @(negedge clk);
        @(negedge clk);
        check("mid w_yellow", 8'(light_state), 8'd5);
        #2 rst = 1'b0;
        #1;
        check("async mid-phase reset", 8'(light_state), 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        expect_phase("post-reset all_red", 4'd0, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
